// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: shared FSM states, default key length and widths for the XOR key scheduler
package xor_cipher_pkg;
  typedef enum logic [1:0] {S_NOKEY, S_LOAD, S_RUN} state_t;
  localparam int KEY_BYTES_DEF = 4;
  localparam int BYTE_W = 8;
  localparam int CNT_W = 16;
  localparam int LEN_W = 4;
  localparam int IDX_W = 3;
endpackage

// File: rtl/xor_key_store.sv
// xor_key_store: key byte array with write pointer (key_len) and rotating read index; ports clk/rst_n, restart/append/advance controls, wdata in, key_len/full/rd_key out
module xor_key_store
  import xor_cipher_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              append,
  input  logic              advance,
  input  logic [BYTE_W-1:0] wdata,
  output logic [LEN_W-1:0]  key_len,
  output logic              full,
  output logic [BYTE_W-1:0] rd_key
);
  logic [BYTE_W-1:0] key [8];
  logic [IDX_W-1:0]  rd_idx;
  assign full = key_len == LEN_W'(KEY_BYTES);
  assign rd_key = key[rd_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) key[i] <= '0;
      key_len <= '0;
      rd_idx <= '0;
    end else if (restart) begin
      key[0] <= wdata;
      key_len <= LEN_W'(1);
      rd_idx <= '0;
    end else if (append) begin
      key[key_len[IDX_W-1:0]] <= wdata;
      key_len <= key_len + LEN_W'(1);
    end else if (advance) begin
      rd_idx <= ({1'b0, rd_idx} == key_len - LEN_W'(1)) ? '0 : rd_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/xor_key_sched.sv
// xor_key_sched: XOR byte cipher with in-band key loading; ports in_valid/in_ready/in_key/in_data upstream, out_valid/out_ready/out_data downstream, key_len/key_ovf/byte_cnt status
module xor_key_sched
  import xor_cipher_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_key,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [LEN_W-1:0]  key_len,
  output logic              key_ovf,
  output logic [CNT_W-1:0]  byte_cnt
);
  state_t            state, state_nx;
  logic              key_acc, data_acc, in_load, restart, append, full;
  logic [BYTE_W-1:0] rd_key;
  assign in_load = state == S_LOAD;
  assign in_ready = in_key || (state != S_NOKEY && (!out_valid || out_ready));
  assign key_acc = in_valid && in_key;
  assign data_acc = in_valid && !in_key && in_ready;
  assign restart = key_acc && !in_load;
  assign append = key_acc && in_load && !full;
  xor_key_store #(.KEY_BYTES(KEY_BYTES)) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .append (append),
    .advance(data_acc),
    .wdata  (in_data),
    .key_len(key_len),
    .full   (full),
    .rd_key (rd_key)
  );
  always_comb state_nx = key_acc ? S_LOAD : data_acc ? S_RUN : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_NOKEY;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      byte_cnt <= '0;
      key_ovf <= 1'b0;
    end else begin
      if (data_acc) begin
        out_valid <= 1'b1;
        out_data <= in_data ^ rd_key;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (restart) byte_cnt <= '0;
      else if (data_acc && byte_cnt != '1) byte_cnt <= byte_cnt + CNT_W'(1);
      if (key_acc && in_load && full) key_ovf <= 1'b1;
    end
  end
endmodule
